core_step_sequencer: RTL and testbench

Multi-cycle control sequencer that steps the 64-bit RISC-V core through FETCH, DECODE, EXECUTE and WRITEBACK. It replaces free-running single-cycle stepping. It handshakes with instruction memory and with a multi-cycle ALU unit (MUL/DIV), and gates register-file writes and PC advance. It sits between the IFU and the CONTROL/DATAPATH pair, and it also keeps cycle and retired-instruction counters.

---
 rtl/core_step_sequencer_pkg.sv | 33 +++
 rtl/core_step_sequencer_if.sv | 33 +++
 rtl/core_step_sequencer_counters.sv | 21 ++
 rtl/core_step_sequencer.sv | 71 +++++++
 tb/tb_core_step_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/core_step_sequencer_pkg.sv
// core_step_sequencer_pkg: shared sequencer state encodings, XLEN and RISC-V opcode constants
package core_step_sequencer_pkg;
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WAIT_ALU  = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALTED    = 3'd6,
        S_FAULT     = 3'd7
    } seq_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // M-extension ops are the only ones routed to the multi-cycle ALU
    function automatic logic is_muldiv(input logic [31:0] instr);
        return (instr[6:0] == OP_REG || instr[6:0] == OP_REG32) && instr[31:25] == FUNCT7_MULDIV;
    endfunction
endpackage

// File: rtl/core_step_sequencer_if.sv
// core_step_sequencer_if: sequencer handshake bundle (imem, ALU, CONTROL/DATAPATH, debug, counters)
interface core_step_sequencer_if #(parameter int CNT_W = 64);
    logic             run;
    logic             halt_req;
    logic             imem_req;
    logic             imem_ready;
    logic [31:0]      instr_in;
    logic [31:0]      ir_out;
    logic             ir_load;
    logic             multicycle;
    logic             alu_start;
    logic             alu_done;
    logic             regwrite_in;
    logic             regwrite_out;
    logic             pc_en;
    logic [2:0]       state;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret;

    modport slave (
        input  run, halt_req, imem_ready, instr_in, multicycle, alu_done, regwrite_in,
        output imem_req, ir_out, ir_load, alu_start, regwrite_out, pc_en, state, halted, fault,
               cycle_count, instret
    );

    modport master (
        output run, halt_req, imem_ready, instr_in, multicycle, alu_done, regwrite_in,
        input  imem_req, ir_out, ir_load, alu_start, regwrite_out, pc_en, state, halted, fault,
               cycle_count, instret
    );
endinterface

// File: rtl/core_step_sequencer_counters.sv
// seq_counters: free-wrapping active-cycle and retired-instruction counters (ports: clock, reset, active, retire -> cycle_count, instret)
module seq_counters #(
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             active,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (active) cycle_count <= cycle_count + CNT_W'(1);
            if (retire) instret     <= instret + CNT_W'(1);
        end
    end
endmodule

// File: rtl/core_step_sequencer.sv
// core_step_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer (ports: clock, reset, bus = handshake/IR/gating/debug/counters)
module core_step_sequencer
    import core_step_sequencer_pkg::*;
#(
    parameter int CNT_W          = 64,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    core_step_sequencer_if.slave   bus
);
    seq_state_t st;
    logic [31:0] ir;
    logic [TMR_W-1:0] timer;
    logic halt_pending;
    logic stop;
    logic live;

    assign stop = halt_pending | bus.halt_req;
    // Outputs are suppressed while reset is held so an aborted instruction never writes or advances PC
    assign live = ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            st           <= S_IDLE;
            ir           <= '0;
            timer        <= '0;
            halt_pending <= 1'b0;
        end else begin
            if (bus.halt_req && st != S_HALTED && st != S_FAULT) halt_pending <= 1'b1;
            case (st)
                S_IDLE:      st <= stop ? S_HALTED : bus.run ? S_FETCH : S_IDLE;
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        ir    <= bus.instr_in;
                        timer <= '0;
                        st    <= S_DECODE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) st <= S_FAULT;
                    end
                end
                S_DECODE:    st <= S_EXECUTE;
                S_EXECUTE:   st <= bus.multicycle ? S_WAIT_ALU : S_WRITEBACK;
                S_WAIT_ALU:  st <= bus.alu_done ? S_WRITEBACK : S_WAIT_ALU;
                S_WRITEBACK: st <= stop ? S_HALTED : bus.run ? S_FETCH : S_IDLE;
                default:     st <= st;
            endcase
        end
    end

    assign bus.imem_req     = live & (st == S_FETCH);
    assign bus.ir_load      = live & (st == S_FETCH) & bus.imem_ready;
    assign bus.alu_start    = live & (st == S_EXECUTE) & bus.multicycle;
    assign bus.regwrite_out = live & (st == S_WRITEBACK) & bus.regwrite_in;
    assign bus.pc_en        = live & (st == S_WRITEBACK);
    assign bus.halted       = live & (st == S_HALTED);
    assign bus.fault        = live & (st == S_FAULT);
    assign bus.state        = st;
    assign bus.ir_out       = ir;

    seq_counters #(.CNT_W(CNT_W)) u_counters (
        .clock       (clock),
        .reset       (reset),
        .active      (st inside {S_FETCH, S_DECODE, S_EXECUTE, S_WAIT_ALU, S_WRITEBACK}),
        .retire      (st == S_WRITEBACK),
        .cycle_count (bus.cycle_count),
        .instret     (bus.instret)
    );
endmodule

// File: tb/tb_core_step_sequencer.sv
// tb_core_step_sequencer: directed self-checking bench for core_step_sequencer
module tb_core_step_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    core_step_sequencer_if #(.CNT_W(64)) bus ();

    core_step_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic quiet();
        bus.run = 0; bus.halt_req = 0; bus.imem_ready = 0; bus.instr_in = '0;
        bus.multicycle = 0; bus.alu_done = 0; bus.regwrite_in = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        quiet();
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        // 1: single-cycle add
        do_reset();
        chk("rst_state", bus.state, 0);
        chk("rst_ir", bus.ir_out, 0);
        chk("rst_cyc", bus.cycle_count, 0);
        chk("rst_inst", bus.instret, 0);
        chk("rst_outs", {bus.imem_req, bus.ir_load, bus.alu_start, bus.regwrite_out, bus.pc_en, bus.halted, bus.fault}, 0);
        bus.run = 1; bus.imem_ready = 1; bus.instr_in = 32'h002081B3; bus.regwrite_in = 1;
        tick(); #1;
        chk("t1_c1_state", bus.state, 1);
        chk("t1_c1_ir_load", bus.ir_load, 1);
        chk("t1_c1_imem_req", bus.imem_req, 1);
        chk("t1_c1_pc_en", bus.pc_en, 0);
        tick(); #1;
        chk("t1_c2_state", bus.state, 2);
        chk("t1_c2_ir", bus.ir_out, 32'h002081B3);
        chk("t1_c2_ir_load", bus.ir_load, 0);
        tick(); #1;
        chk("t1_c3_state", bus.state, 3);
        chk("t1_c3_wr_pc", {bus.regwrite_out, bus.pc_en, bus.alu_start}, 0);
        tick(); #1;
        chk("t1_c4_state", bus.state, 5);
        chk("t1_c4_wr_pc", {bus.regwrite_out, bus.pc_en}, 2'b11);
        tick(); #1;
        chk("t1_inst", bus.instret, 1);
        chk("t1_cyc", bus.cycle_count, 4);
        chk("t1_refetch", bus.state, 1);

        // 2: multicycle op, alu_done 5 cycles after alu_start
        do_reset();
        bus.run = 1; bus.imem_ready = 1; bus.instr_in = 32'h022081B3; bus.multicycle = 1; bus.regwrite_in = 1;
        tick(); tick(); tick(); #1;
        chk("t2_c3_state", bus.state, 3);
        chk("t2_c3_alu_start", bus.alu_start, 1);
        for (int i = 4; i <= 7; i++) begin
            tick(); #1;
            chk("t2_wait_state", bus.state, 4);
            chk("t2_wait_start_pc", {bus.alu_start, bus.pc_en}, 0);
        end
        tick();
        bus.alu_done = 1; #1;
        chk("t2_c8_state", bus.state, 4);
        tick();
        bus.alu_done = 0; bus.run = 0; #1;
        chk("t2_c9_state", bus.state, 5);
        chk("t2_c9_wr_pc", {bus.regwrite_out, bus.pc_en}, 2'b11);
        tick(); #1;
        chk("t2_idle", bus.state, 0);
        chk("t2_inst", bus.instret, 1);
        chk("t2_cyc", bus.cycle_count, 9);
        bus.alu_done = 1;
        tick(); #1;
        chk("t2_done_ignored", bus.state, 0);

        // 3a: fetch timeout
        do_reset();
        bus.run = 1;
        tick();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_fetch_state", bus.state, 1);
            tick();
        end
        #1;
        chk("t3_fault_state", bus.state, 7);
        chk("t3_fault", bus.fault, 1);
        bus.imem_ready = 1; bus.alu_done = 1; bus.halt_req = 1;
        for (int i = 0; i < 20; i++) tick();
        #1;
        chk("t3_fault_sticky", bus.state, 7);
        chk("t3_fault_outs", {bus.fault, bus.halted, bus.imem_req}, 3'b100);

        // 3b: ready arrives on the last allowed fetch cycle
        do_reset();
        bus.run = 1; bus.instr_in = 32'h00A00093;
        tick();
        for (int i = 0; i < 15; i++) tick();
        bus.imem_ready = 1; #1;
        chk("t3b_last_fetch", bus.state, 1);
        chk("t3b_ir_load", bus.ir_load, 1);
        tick(); #1;
        chk("t3b_decode", bus.state, 2);
        chk("t3b_no_fault", bus.fault, 0);
        chk("t3b_ir", bus.ir_out, 32'h00A00093);

        // 4: halt_req during DECODE of 2nd instruction
        do_reset();
        bus.run = 1; bus.imem_ready = 1; bus.instr_in = 32'h002081B3; bus.regwrite_in = 1;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("t4_c6_decode", bus.state, 2);
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        tick(); #1;
        chk("t4_c8_wb", bus.state, 5);
        chk("t4_c8_pc_en", bus.pc_en, 1);
        tick(); #1;
        chk("t4_halted_state", bus.state, 6);
        chk("t4_halted", bus.halted, 1);
        chk("t4_inst", bus.instret, 2);
        tick(); tick(); #1;
        chk("t4_sticky", {bus.halted, bus.imem_req}, 2'b10);
        chk("t4_cyc_frozen", bus.cycle_count, 8);

        // 5: reset during WAIT_ALU
        do_reset();
        bus.run = 1; bus.imem_ready = 1; bus.multicycle = 1; bus.regwrite_in = 1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("t5_wait", bus.state, 4);
        reset = 1; bus.alu_done = 1; #1;
        chk("t5_rst_outs", {bus.regwrite_out, bus.pc_en}, 0);
        tick(); #1;
        chk("t5_idle", bus.state, 0);
        chk("t5_counters", {bus.cycle_count, bus.instret}, 0);
        reset = 0; bus.run = 0;
        tick(); #1;
        chk("t5_stay_idle", bus.state, 0);
        chk("t5_no_wr", {bus.regwrite_out, bus.pc_en}, 0);
        chk("t5_inst", bus.instret, 0);

        // 6: run dropped during EXECUTE
        do_reset();
        bus.run = 1; bus.imem_ready = 1; bus.regwrite_in = 0;
        tick(); tick(); tick();
        bus.run = 0; #1;
        chk("t6_exec", bus.state, 3);
        tick(); #1;
        chk("t6_wb", bus.state, 5);
        chk("t6_wr_pc", {bus.regwrite_out, bus.pc_en}, 2'b01);
        tick(); #1;
        chk("t6_idle", bus.state, 0);
        chk("t6_inst", bus.instret, 1);
        tick(); tick(); #1;
        chk("t6_cyc_frozen", bus.cycle_count, 4);
        bus.run = 1;
        tick(); #1;
        chk("t6_refetch", bus.state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
